date_set_ctrl: RTL and testbench

- Keypad-driven setting sequencer for the month/date/year register block.
- Turns debounced key events into that block's field-select controls (switch_year, sel_mon_date, sel_ten) and a single-cycle command strobe (key_out + pressed).
- Adds field cursoring, hold-to-repeat, idle timeout and a digit blink mask for the 7-segment driver.

---
 rtl/date_set_ctrl_if.sv | 26 ++
 rtl/date_set_ctrl.sv | 144 ++++++++++++++
 tb/tb_date_set_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/date_set_ctrl_if.sv
// Keypad-side and register-block-side signals of the date setting sequencer.
// The slave modport is the sequencer; the master drives keys and watches controls.
interface date_set_ctrl_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       switch_year;
  logic       sel_mon_date;
  logic       sel_ten;
  logic [3:0] key_out;
  logic       pressed;
  logic       set_mode;
  logic [3:0] blink_mask;
  logic       timeout;

  modport master (
    output key_valid, key_code,
    input  switch_year, sel_mon_date, sel_ten, key_out, pressed, set_mode,
           blink_mask, timeout
  );

  modport slave (
    input  key_valid, key_code,
    output switch_year, sel_mon_date, sel_ten, key_out, pressed, set_mode,
           blink_mask, timeout
  );
endinterface

// File: rtl/date_set_ctrl.sv
// Keypad setting sequencer for the month/date/year block: field cursor, inc/dec
// command strobes with hold-to-repeat, idle timeout and a digit blink mask.
module date_set_ctrl #(
  parameter int TIMEOUT_CYC = 1000,
  parameter int REPEAT_DLY  = 50,
  parameter int REPEAT_PER  = 10,
  parameter int BLINK_HALF  = 25,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  date_set_ctrl_if.slave   ctl_if
);

  typedef enum logic [2:0] {
    IDLE, MON_T, MON_S, DATE_T, DATE_S, YEAR_T, YEAR_S
  } state_t;

  localparam logic [3:0] KEY_A = 4'd10;
  localparam logic [3:0] KEY_B = 4'd11;
  localparam logic [3:0] KEY_C = 4'd12;
  localparam logic [3:0] KEY_D = 4'd13;

  state_t             state_q, state_d;
  logic               key_valid_q;
  logic               armed_q;
  logic [3:0]         held_code_q;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]   to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;

  logic in_set, key_edge, recog, ab_evt, hold_match, rep_fire, expire;

  function automatic state_t next_field(state_t s);
    case (s)
      MON_T:   return MON_S;
      MON_S:   return DATE_T;
      DATE_T:  return DATE_S;
      DATE_S:  return YEAR_T;
      YEAR_T:  return YEAR_S;
      default: return MON_T;
    endcase
  endfunction

  // {switch_year, sel_mon_date, sel_ten}
  function automatic logic [2:0] sel_of(state_t s);
    case (s)
      MON_T:   return 3'b011;
      MON_S:   return 3'b010;
      DATE_T:  return 3'b001;
      YEAR_T:  return 3'b101;
      YEAR_S:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] mask_of(state_t s);
    case (s)
      MON_T:          return 4'b1000;
      MON_S:          return 4'b0100;
      DATE_T, YEAR_T: return 4'b0010;
      DATE_S, YEAR_S: return 4'b0001;
      default:        return 4'b0000;
    endcase
  endfunction

  always_comb begin
    in_set     = (state_q != IDLE);
    // armed_q blocks a key that was already held when reset was released
    key_edge   = ctl_if.key_valid && !key_valid_q && armed_q;
    recog      = key_edge && (ctl_if.key_code >= KEY_A) && (ctl_if.key_code <= KEY_D);
    ab_evt     = recog && in_set && ((ctl_if.key_code == KEY_A) || (ctl_if.key_code == KEY_B));
    hold_match = (hold_cnt_q != '0) && ctl_if.key_valid && (ctl_if.key_code == held_code_q);
    rep_fire   = in_set && hold_match && (hold_cnt_q == CNT_W'(REPEAT_DLY - 1));
    expire     = in_set && !recog && !rep_fire && (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    state_d = state_q;
    if (recog) begin
      if (ctl_if.key_code == KEY_C)      state_d = next_field(state_q);
      else if (ctl_if.key_code == KEY_D) state_d = IDLE;
    end else if (expire) begin
      state_d = IDLE;
    end

    // Nonzero hold count means a repeat-eligible key is held; reloading to
    // REPEAT_DLY-REPEAT_PER spaces later strobes by REPEAT_PER cycles.
    hold_cnt_d = '0;
    if (state_d != IDLE) begin
      if (ab_evt)          hold_cnt_d = CNT_W'(1);
      else if (rep_fire)   hold_cnt_d = CNT_W'(REPEAT_DLY - REPEAT_PER);
      else if (hold_match) hold_cnt_d = hold_cnt_q + 1'b1;
    end

    to_cnt_d = (recog || rep_fire || state_d == IDLE) ? '0 : to_cnt_q + 1'b1;

    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (state_d != state_q || state_d == IDLE) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == CNT_W'(BLINK_HALF - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= IDLE;
      key_valid_q         <= 1'b0;
      armed_q             <= 1'b0;
      held_code_q         <= '0;
      hold_cnt_q          <= '0;
      to_cnt_q            <= '0;
      blink_cnt_q         <= '0;
      phase_q             <= 1'b0;
      ctl_if.switch_year  <= 1'b0;
      ctl_if.sel_mon_date <= 1'b0;
      ctl_if.sel_ten      <= 1'b0;
      ctl_if.key_out      <= '0;
      ctl_if.pressed      <= 1'b0;
      ctl_if.set_mode     <= 1'b0;
      ctl_if.blink_mask   <= '0;
      ctl_if.timeout      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_valid_q <= ctl_if.key_valid;
      armed_q     <= armed_q | ~ctl_if.key_valid;
      if (ab_evt) held_code_q <= ctl_if.key_code;
      hold_cnt_q  <= hold_cnt_d;
      to_cnt_q    <= to_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      {ctl_if.switch_year, ctl_if.sel_mon_date, ctl_if.sel_ten} <= sel_of(state_d);
      ctl_if.pressed    <= ab_evt | rep_fire;
      ctl_if.key_out    <= ab_evt ? ctl_if.key_code : (rep_fire ? held_code_q : 4'd0);
      ctl_if.set_mode   <= (state_d != IDLE);
      ctl_if.blink_mask <= phase_d ? mask_of(state_d) : 4'b0000;
      ctl_if.timeout    <= expire;
    end
  end

endmodule

// File: tb/tb_date_set_ctrl.sv
// Directed bench for date_set_ctrl: inputs driven and outputs sampled on the
// falling clock edge, so each sample shows the result of the preceding rising edge.
module tb_date_set_ctrl;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  date_set_ctrl_if bus ();

  date_set_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ctl_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  sel;
  logic [13:0] outs;
  assign sel  = {bus.switch_year, bus.sel_mon_date, bus.sel_ten};
  assign outs = {sel, bus.key_out, bus.pressed, bus.set_mode, bus.blink_mask, bus.timeout};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Release for one edge, then hold the key; the next tick is the event edge.
  task automatic press(input logic [3:0] code);
    bus.key_valid = 1'b0;
    tick();
    bus.key_valid = 1'b1;
    bus.key_code  = code;
  endtask

  // Returns right after the event edge with the key already released.
  task automatic tap(input logic [3:0] code);
    press(code);
    tick();
    bus.key_valid = 1'b0;
    $display("[TB] tap code %0d -> sel=%b set_mode=%b pressed=%b key_out=%0d",
             code, sel, bus.set_mode, bus.pressed, bus.key_out);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int strobes;
    logic exp_p;
    logic [2:0] exp_sel [6];
    exp_sel[0] = 3'b010; exp_sel[1] = 3'b001; exp_sel[2] = 3'b000;
    exp_sel[3] = 3'b101; exp_sel[4] = 3'b100; exp_sel[5] = 3'b011;
    n_tests = 0;
    n_fail  = 0;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_outs", 32'(outs), 32'd0);
    rst_n = 1'b1;
    tick();

    // Enter set mode
    tap(4'd12);
    chk("c_sel_mon_t", 32'(sel), 32'b011);
    chk("c_set_mode", 32'(bus.set_mode), 32'd1);
    chk("c_no_press", 32'(bus.pressed), 32'd0);
    repeat (24) tick();
    chk("blink_off", 32'(bus.blink_mask), 32'b0000);
    tick();
    chk("blink_on", 32'(bus.blink_mask), 32'b1000);

    // Increment strobe lasts one cycle
    tap(4'd10);
    chk("a_pressed", 32'(bus.pressed), 32'd1);
    chk("a_key_out", 32'(bus.key_out), 32'd10);
    tick();
    chk("a_pressed_end", 32'(bus.pressed), 32'd0);
    chk("a_key_out_end", 32'(bus.key_out), 32'd0);

    // Unrecognised code is ignored
    tap(4'd5);
    chk("x_no_press", 32'(bus.pressed), 32'd0);
    chk("x_sel", 32'(sel), 32'b011);

    // Field cursoring wraps
    for (int i = 0; i < 6; i++) begin
      tap(4'd12);
      chk($sformatf("c_step%0d", i), 32'(sel), 32'(exp_sel[i]));
    end
    tap(4'd13);
    chk("d_sel", 32'(sel), 32'd0);
    chk("d_set_mode", 32'(bus.set_mode), 32'd0);

    // Hold B in DATE_S for 100 cycles
    repeat (4) tap(4'd12);
    chk("date_s_sel", 32'(sel), 32'b000);
    chk("date_s_mode", 32'(bus.set_mode), 32'd1);
    press(4'd11);
    strobes = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      exp_p = (i == 1) || (i >= 50 && (i % 10) == 0);
      chk($sformatf("hold_p%0d", i), 32'(bus.pressed), 32'(exp_p));
      if (bus.pressed) begin
        strobes++;
        chk($sformatf("hold_k%0d", i), 32'(bus.key_out), 32'd11);
      end
    end
    bus.key_valid = 1'b0;
    chk("hold_strobes", 32'(strobes), 32'd7);
    tick();
    chk("hold_release", 32'(bus.pressed), 32'd0);

    // Idle timeout in YEAR_S
    tap(4'd12);
    tap(4'd12);
    chk("year_s_sel", 32'(sel), 32'b100);
    repeat (999) tick();
    chk("to_not_yet", 32'(bus.timeout), 32'd0);
    chk("to_still_set", 32'(bus.set_mode), 32'd1);
    tick();
    chk("to_pulse", 32'(bus.timeout), 32'd1);
    chk("to_mode", 32'(bus.set_mode), 32'd0);
    chk("to_blink", 32'(bus.blink_mask), 32'd0);
    chk("to_sel", 32'(sel), 32'd0);
    tick();
    chk("to_pulse_end", 32'(bus.timeout), 32'd0);

    // A event on the expiry edge wins
    tap(4'd12);
    repeat (999) tick();
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd10;
    tick();
    bus.key_valid = 1'b0;
    chk("race_no_to", 32'(bus.timeout), 32'd0);
    chk("race_pressed", 32'(bus.pressed), 32'd1);
    chk("race_key", 32'(bus.key_out), 32'd10);
    chk("race_mode", 32'(bus.set_mode), 32'd1);
    tick();
    chk("race_no_to2", 32'(bus.timeout), 32'd0);

    // A held and D tapped in IDLE do nothing
    tap(4'd13);
    press(4'd10);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("idle_a%0d", i), 32'(bus.pressed), 32'd0);
    end
    tap(4'd13);
    chk("idle_d_press", 32'(bus.pressed), 32'd0);
    chk("idle_d_mode", 32'(bus.set_mode), 32'd0);

    // Reset in the middle of a held-A repeat
    tap(4'd12);
    press(4'd10);
    repeat (55) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", 32'(outs), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      chk($sformatf("post_rst_p%0d", i), 32'(bus.pressed), 32'd0);
    end
    bus.key_valid = 1'b0;
    tick();

    // C held across reset release is not an event
    rst_n = 1'b0;
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd12;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("held_c_mode", 32'(bus.set_mode), 32'd0);
    bus.key_valid = 1'b0;
    tick();
    chk("held_c_rel", 32'(bus.set_mode), 32'd0);
    tap(4'd12);
    chk("repress_mode", 32'(bus.set_mode), 32'd1);
    chk("repress_sel", 32'(sel), 32'b011);
    tap(4'd10);
    chk("repress_a", 32'(bus.pressed), 32'd1);
    chk("repress_key", 32'(bus.key_out), 32'd10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
